// File: rtl/matrix_operand_loader.sv
// Byte-stream loader for the 2x2 matrix multiplier operands.
// Optional WAIT timeout: define MATRIX_LOADER_TIMEOUT_EN.
module matrix_operand_loader #(
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_sof,
  output logic              in_ready,
  output logic [DATA_W-1:0] a11,
  output logic [DATA_W-1:0] a12,
  output logic [DATA_W-1:0] a21,
  output logic [DATA_W-1:0] a22,
  output logic [DATA_W-1:0] b11,
  output logic [DATA_W-1:0] b12,
  output logic [DATA_W-1:0] b21,
  output logic [DATA_W-1:0] b22,
  output logic              mul_start,
  input  logic              mul_done,
  output logic              busy,
  output logic              err_sync
`ifdef MATRIX_LOADER_TIMEOUT_EN
  ,
  output logic              err_timeout
`endif
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    S_LOAD,
    S_FIRE,
    S_WAIT
  } state_t;

  state_t            state;
  logic [2:0]        idx;
  logic [DATA_W-1:0] ops [8];

`ifdef MATRIX_LOADER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt;
`endif

  // Ready and busy follow the state, forced low while reset is held.
  assign in_ready = ~rst & (state == S_LOAD);
  assign busy     = ~rst & (state != S_LOAD);

  assign a11 = ops[0];
  assign a12 = ops[1];
  assign a21 = ops[2];
  assign a22 = ops[3];
  assign b11 = ops[4];
  assign b12 = ops[5];
  assign b21 = ops[6];
  assign b22 = ops[7];

  // Frame capture, fire/wait sequencing and error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_LOAD;
      idx       <= 3'd0;
      mul_start <= 1'b0;
      err_sync  <= 1'b0;
      for (int i = 0; i < 8; i++) ops[i] <= '0;
`ifdef MATRIX_LOADER_TIMEOUT_EN
      wait_cnt    <= '0;
      err_timeout <= 1'b0;
`endif
    end else begin
      mul_start <= 1'b0;
      err_sync  <= 1'b0;
`ifdef MATRIX_LOADER_TIMEOUT_EN
      err_timeout <= 1'b0;
`endif
      unique case (state)
        S_LOAD: begin
          if (in_valid) begin
            if (in_sof) begin
              ops[0]   <= in_data;
              idx      <= 3'd1;
              err_sync <= (idx != 3'd0);
            end else begin
              ops[idx] <= in_data;
              if (idx == 3'd7) begin
                idx       <= 3'd0;
                state     <= S_FIRE;
                mul_start <= 1'b1;
              end else begin
                idx <= idx + 3'd1;
              end
            end
          end
        end
        S_FIRE: begin
          state <= S_WAIT;
`ifdef MATRIX_LOADER_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        S_WAIT: begin
          if (mul_done) begin
            state <= S_LOAD;
`ifdef MATRIX_LOADER_TIMEOUT_EN
          end else if (wait_cnt == CNT_LAST) begin
            state       <= S_LOAD;
            err_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
`endif
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule
